// File: rtl/adc_decimator_if.sv
// Sample stream into, and window statistics out of, the adc_decimator block.
// master is the ADC plus result consumer side; slave is the decimator itself.
interface adc_decimator_if #(
    parameter int FINE_BITS = 7
);
    logic                 sample_valid;
    logic [FINE_BITS:0]   sample_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [FINE_BITS:0]   out_mean;
    logic [FINE_BITS:0]   out_min;
    logic [FINE_BITS:0]   out_max;
    logic                 overrun;
    logic [7:0]           drop_count;

    modport master (
        output sample_valid, sample_data, out_ready,
        input  out_valid, out_mean, out_min, out_max, overrun, drop_count
    );

    modport slave (
        input  sample_valid, sample_data, out_ready,
        output out_valid, out_mean, out_min, out_max, overrun, drop_count
    );
endinterface

// File: rtl/adc_decimator.sv
// Reduces each window of 2^LOG2_AVG ADC samples to truncated mean, min and max,
// held in a single-entry valid/ready register; windows that find it occupied are dropped.
module adc_decimator #(
    parameter int FINE_BITS = 7,
    parameter int LOG2_AVG  = 4
) (
    input  logic           int_osc,
    input  logic           reset_n,
    input  logic           clear,
    adc_decimator_if.slave bus
);
    localparam int SW = FINE_BITS + 1;
    localparam int AW = SW + LOG2_AVG;

    localparam logic [LOG2_AVG-1:0] CNT_LAST = '1;
    localparam logic [SW-1:0]       MN_INIT  = '1;
    localparam logic [7:0]          DROP_MAX = 8'hFF;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

    // Window accumulation state
    logic [AW-1:0]       acc_q, acc_d;
    logic [LOG2_AVG-1:0] cnt_q, cnt_d;
    logic [SW-1:0]       mn_q, mn_d;
    logic [SW-1:0]       mx_q, mx_d;

    // Output register and statistics
    out_state_e          state_q, state_d;
    logic [SW-1:0]       mean_q, mean_d;
    logic [SW-1:0]       min_q, min_d;
    logic [SW-1:0]       max_q, max_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          drop_q, drop_d;

    logic                accept;
    logic                last;
    logic                offer;
    logic                handshake;
    logic [AW-1:0]       sum_w;
    logic [SW-1:0]       min_w;
    logic [SW-1:0]       max_w;

    assign accept    = bus.sample_valid && !clear;
    assign last      = (cnt_q == CNT_LAST);
    assign offer     = accept && last;
    assign handshake = (state_q == S_FULL) && bus.out_ready;

    // Width is sized so that N full-scale samples fit without wrap.
    assign sum_w = acc_q + AW'(bus.sample_data);
    assign min_w = (bus.sample_data < mn_q) ? bus.sample_data : mn_q;
    assign max_w = (bus.sample_data > mx_q) ? bus.sample_data : mx_q;

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        mn_d  = mn_q;
        mx_d  = mx_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            mn_d  = MN_INIT;
            mx_d  = '0;
        end else if (accept) begin
            cnt_d = cnt_q + LOG2_AVG'(1);
            if (last) begin
                acc_d = '0;
                mn_d  = MN_INIT;
                mx_d  = '0;
            end else begin
                acc_d = sum_w;
                mn_d  = min_w;
                mx_d  = max_w;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mean_d    = mean_q;
        min_d     = min_q;
        max_d     = max_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        if (clear) begin
            state_d   = S_EMPTY;
            overrun_d = 1'b0;
            drop_d    = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (offer) begin
                        state_d = S_FULL;
                        mean_d  = sum_w[AW-1:LOG2_AVG];
                        min_d   = min_w;
                        max_d   = max_w;
                    end
                end
                S_FULL: begin
                    if (offer && handshake) begin
                        mean_d = sum_w[AW-1:LOG2_AVG];
                        min_d  = min_w;
                        max_d  = max_w;
                    end else if (offer) begin
                        overrun_d = 1'b1;
                        if (drop_q != DROP_MAX) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end else if (handshake) begin
                        state_d = S_EMPTY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            mn_q  <= MN_INIT;
            mx_q  <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            mn_q  <= mn_d;
            mx_q  <= mx_d;
        end
    end

    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_EMPTY;
            mean_q    <= '0;
            min_q     <= '0;
            max_q     <= '0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            mean_q    <= mean_d;
            min_q     <= min_d;
            max_q     <= max_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.out_valid  = (state_q == S_FULL);
    assign bus.out_mean   = mean_q;
    assign bus.out_min    = min_q;
    assign bus.out_max    = max_q;
    assign bus.overrun    = overrun_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_adc_decimator.sv
// Scoreboard bench for adc_decimator: a behavioural window/output-register model
// predicts results, which are compared while held and when consumed.
module tb_adc_decimator;
    localparam int FINE_BITS = 7;
    localparam int LOG2_AVG  = 4;
    localparam int N         = 1 << LOG2_AVG;
    localparam int SW        = FINE_BITS + 1;

    typedef struct packed {
        logic [SW-1:0] mean;
        logic [SW-1:0] mn;
        logic [SW-1:0] mx;
    } result_t;

    logic int_osc = 1'b0;
    logic reset_n;
    logic clear;

    adc_decimator_if #(.FINE_BITS(FINE_BITS)) bus ();

    adc_decimator #(
        .FINE_BITS(FINE_BITS),
        .LOG2_AVG (LOG2_AVG)
    ) dut (
        .int_osc(int_osc),
        .reset_n(reset_n),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 int_osc = ~int_osc;

    result_t sb[$];
    bit      m_full;
    bit      m_ovr;
    int      m_drop;
    int      m_sum, m_min, m_max, m_cnt;
    int      n_cmp = 0;
    int      n_bad = 0;

    task automatic model_window_reset();
        m_sum = 0;
        m_min = 1 << SW;
        m_max = -1;
        m_cnt = 0;
    endtask

    task automatic model_reset();
        model_window_reset();
        sb.delete();
        m_full = 1'b0;
        m_ovr  = 1'b0;
        m_drop = 0;
    endtask

    // Called at a falling edge with inputs already set: checks the DUT against
    // the model, advances the model across the next rising edge, returns at the falling edge.
    task automatic tick();
        result_t res;
        bit      offer;
        bit      hs;
        int      s;
        n_cmp++;
        if (bus.out_valid !== m_full) begin
            n_bad++;
            $display("FAIL out_valid: got %b expected %b at %0t", bus.out_valid, m_full, $time);
        end
        n_cmp++;
        if (bus.overrun !== m_ovr) begin
            n_bad++;
            $display("FAIL overrun: got %b expected %b at %0t", bus.overrun, m_ovr, $time);
        end
        n_cmp++;
        if (bus.drop_count !== 8'(m_drop)) begin
            n_bad++;
            $display("FAIL drop_count: got %0d expected %0d at %0t", bus.drop_count, m_drop, $time);
        end
        if (m_full && sb.size() != 0) begin
            n_cmp++;
            if ({bus.out_mean, bus.out_min, bus.out_max} !== sb[0]) begin
                n_bad++;
                $display("FAIL held_result: got mean=%h min=%h max=%h expected mean=%h min=%h max=%h at %0t",
                         bus.out_mean, bus.out_min, bus.out_max, sb[0].mean, sb[0].mn, sb[0].mx, $time);
            end
        end
        offer = 1'b0;
        res   = '0;
        hs    = m_full && (bus.out_ready === 1'b1);
        if (clear) begin
            model_reset();
        end else begin
            if (bus.sample_valid) begin
                s = int'(bus.sample_data);
                m_sum += s;
                if (s < m_min) m_min = s;
                if (s > m_max) m_max = s;
                m_cnt++;
                if (m_cnt == N) begin
                    res.mean = SW'(m_sum / N);
                    res.mn   = SW'(m_min);
                    res.mx   = SW'(m_max);
                    offer    = 1'b1;
                    model_window_reset();
                end
            end
            if (offer) begin
                if (!m_full || hs) begin
                    if (hs) void'(sb.pop_front());
                    sb.push_back(res);
                    m_full = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                    if (m_drop != 255) m_drop++;
                end
            end else if (hs) begin
                void'(sb.pop_front());
                m_full = 1'b0;
            end
        end
        @(posedge int_osc);
        @(negedge int_osc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [SW-1:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic send_window(input logic [SW-1:0] d);
        for (int i = 0; i < N; i++) send(d);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge int_osc);
        for (int i = 0; i < 8; i++) begin
            bus.sample_valid = 1'($urandom);
            bus.sample_data  = SW'($urandom);
            clear            = 1'($urandom);
            bus.out_ready    = 1'($urandom);
            @(negedge int_osc);
            n_cmp++;
            if ({bus.out_valid, bus.out_mean, bus.out_min, bus.out_max, bus.overrun, bus.drop_count} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got v=%b mean=%h min=%h max=%h ovr=%b drops=%0d expected all zero",
                         bus.out_valid, bus.out_mean, bus.out_min, bus.out_max, bus.overrun, bus.drop_count);
            end
        end
        bus.sample_valid = 1'b0;
        clear = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b1;
        idle(100);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_constant();
        for (int i = 0; i < N; i++) begin
            send(8'h80);
            if (i < N - 1) idle(2);
        end
        n_cmp++;
        if ({bus.out_valid, bus.out_mean, bus.out_min, bus.out_max} !== {1'b1, 8'h80, 8'h80, 8'h80}) begin
            n_bad++;
            $display("FAIL const_window: got v=%b mean=%h min=%h max=%h expected v=1 mean=80 min=80 max=80",
                     bus.out_valid, bus.out_mean, bus.out_min, bus.out_max);
        end
        consume();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL const_consumed: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) send(SW'(i));
        n_cmp++;
        if ({bus.out_mean, bus.out_min, bus.out_max} !== {8'h07, 8'h00, 8'h0F}) begin
            n_bad++;
            $display("FAIL ramp_window: got mean=%h min=%h max=%h expected mean=07 min=00 max=0f",
                     bus.out_mean, bus.out_min, bus.out_max);
        end
        consume();
        send_window(8'hFF);
        n_cmp++;
        if ({bus.out_mean, bus.out_min, bus.out_max} !== {8'hFF, 8'hFF, 8'hFF}) begin
            n_bad++;
            $display("FAIL full_scale_window: got mean=%h min=%h max=%h expected ff ff ff",
                     bus.out_mean, bus.out_min, bus.out_max);
        end
        consume();
    endtask

    task automatic test_backpressure();
        send_window(8'h10);
        send_window(8'h20);
        n_cmp++;
        if ({bus.out_mean, bus.out_min, bus.out_max, bus.overrun, bus.drop_count} !== {8'h10, 8'h10, 8'h10, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL first_drop: got mean=%h min=%h max=%h ovr=%b drops=%0d expected 10 10 10 1 1",
                     bus.out_mean, bus.out_min, bus.out_max, bus.overrun, bus.drop_count);
        end
        for (int w = 0; w < 300; w++) send_window(SW'(8'h20 + w));
        n_cmp++;
        if ({bus.out_mean, bus.overrun, bus.drop_count} !== {8'h10, 1'b1, 8'd255}) begin
            n_bad++;
            $display("FAIL drop_saturate: got mean=%h ovr=%b drops=%0d expected 10 1 255",
                     bus.out_mean, bus.overrun, bus.drop_count);
        end
        pulse_clear();
        n_cmp++;
        if ({bus.out_valid, bus.overrun, bus.drop_count} !== {1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL clear_stats: got v=%b ovr=%b drops=%0d expected 0 0 0",
                     bus.out_valid, bus.overrun, bus.drop_count);
        end
    endtask

    task automatic test_same_cycle();
        send_window(8'h30);
        for (int i = 0; i < N - 1; i++) send(SW'(8'h40 + i));
        bus.out_ready = 1'b1;
        send(SW'(8'h40 + N - 1));
        bus.out_ready = 1'b0;
        n_cmp++;
        if ({bus.out_valid, bus.out_mean, bus.out_min, bus.out_max, bus.overrun, bus.drop_count}
                !== {1'b1, 8'h47, 8'h40, 8'h4F, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL same_cycle_handoff: got v=%b mean=%h min=%h max=%h ovr=%b drops=%0d expected 1 47 40 4f 0 0",
                     bus.out_valid, bus.out_mean, bus.out_min, bus.out_max, bus.overrun, bus.drop_count);
        end
        consume();
    endtask

    task automatic test_disruption();
        for (int i = 0; i < 5; i++) send(8'hFF);
        clear = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data = 8'hFF;
        tick();
        clear = 1'b0;
        bus.sample_valid = 1'b0;
        send_window(8'h10);
        n_cmp++;
        if ({bus.out_mean, bus.out_min, bus.out_max} !== {8'h10, 8'h10, 8'h10}) begin
            n_bad++;
            $display("FAIL after_clear: got mean=%h min=%h max=%h expected 10 10 10",
                     bus.out_mean, bus.out_min, bus.out_max);
        end
        consume();
        send_window(8'h50);
        for (int i = 0; i < 5; i++) send(8'hFF);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_flush: got out_valid=%b expected 0", bus.out_valid);
        end
        model_reset();
        #1;
        reset_n = 1'b1;
        send_window(8'h10);
        n_cmp++;
        if ({bus.out_valid, bus.out_mean, bus.out_min, bus.out_max} !== {1'b1, 8'h10, 8'h10, 8'h10}) begin
            n_bad++;
            $display("FAIL after_reset_pulse: got v=%b mean=%h min=%h max=%h expected 1 10 10 10",
                     bus.out_valid, bus.out_mean, bus.out_min, bus.out_max);
        end
        consume();
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_backpressure();
        test_same_cycle();
        test_disruption();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_decimator.md
# adc_decimator

Downstream stage for the `adcv` ramp ADC: consumes one sample per conversion strobe and reduces each window of 2^LOG2_AVG samples to a truncated mean, window minimum and window maximum. Results are presented on a single-entry valid/ready output register. Windows that complete while the register is still occupied are dropped and counted. Sits between the ADC and whatever consumer (audio path, LED debug, serial dump) runs on the HF oscillator clock domain.

## Interface
- FINE_BITS, 7, sample width is FINE_BITS+1 bits (matches ADC `digital_out`)
- LOG2_AVG, 4, window length N = 2^LOG2_AVG; legal range 1..8
- int_osc  input  1  clock, HF oscillator; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- clear  input  1  synchronous: restart window, flush output, clear statistics
- sample_valid  input  1  one-cycle strobe: sample_data holds a new conversion
- sample_data  input  FINE_BITS+1  ADC code, unsigned
- out_valid  output  1  result register occupied
- out_ready  input  1  consumer accepts result when out_valid && out_ready
- out_mean  output  FINE_BITS+1  floor(sum/N)
- out_min  output  FINE_BITS+1  smallest sample in window
- out_max  output  FINE_BITS+1  largest sample in window
- overrun  output  1  sticky: at least one window dropped since reset/clear
- drop_count  output  8  number of dropped windows, saturates at 255

## Operation
- Accumulator `acc` is FINE_BITS+1+LOG2_AVG bits unsigned; it never overflows. Sample counter `cnt` is LOG2_AVG bits; running `mn` and `mx` are FINE_BITS+1 bits.
- Accepted sample (sample_valid high at a rising edge, clear low):
  - cnt != N-1: acc += sample, mn = min(mn, sample), mx = max(mx, sample), cnt += 1.
  - cnt == N-1 (last sample): compute final sum = acc + sample, and final min/max including the sample. Then acc = 0, mn = all-ones, mx = 0, cnt = 0 (wraps). Result is offered to the output register.
- First sample of each window is handled by the mn/mx init values, with no special case.
- Output register states:
  - EMPTY (out_valid=0), FULL (out_valid=1).
  - EMPTY + result offered -> FULL, loading mean = sum >> LOG2_AVG (truncation), min and max.
  - FULL + handshake, no result offered -> EMPTY.
  - FULL + handshake + result offered in the same cycle -> stays FULL with the new result; not a drop.
  - FULL + no handshake + result offered -> result discarded, overrun=1, drop_count += 1 unless already 255; the held result is unchanged.
- out_mean/min/max are stable while out_valid=1 and out_ready=0.
- clear (priority over everything):
  - acc=0, cnt=0, mn=all-ones, mx=0; out_valid=0; overrun=0; drop_count=0.
  - A sample_valid in the same cycle is discarded.
  - Data outputs may hold stale values but are don't-care while out_valid=0.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset values: out_valid=0, out_mean=0, out_min=0, out_max=0, overrun=0, drop_count=0; internal acc=0, cnt=0, mn=all-ones, mx=0.
- Reset assertion mid-window discards the partial window and any pending result immediately (asynchronous).
- Latency: out_valid rises on the same rising edge that accepts the Nth sample, so it is visible one cycle after the strobe is presented. No combinational path from inputs to outputs.
- Throughput: one sample per cycle (back-to-back sample_valid) is supported. A result is accepted in the same cycle out_valid && out_ready.
- overrun and drop_count update on the edge where the drop occurs.

## Test plan
- Reset: hold reset_n=0 with random inputs -> all outputs 0. Release, with no sample_valid for 100 cycles -> out_valid stays 0.
- FINE_BITS=7, LOG2_AVG=4: 16 strobes of 0x80 spaced 3 cycles apart -> out_valid=1 one cycle after the 16th strobe, with mean=0x80, min=0x80, max=0x80. With out_ready=1 it drops to 0 the next cycle.
- Samples 0,1,...,15 back-to-back -> mean=0x07 (sum 120 truncated), min=0x00, max=0x0F. A second window of 16 x 0xFF -> mean=0xFF, min=max=0xFF, confirming no overflow at sum 4080.
- Backpressure, out_ready=0: window A (all 0x10) then window B (all 0x20) -> B dropped, outputs still 0x10, overrun=1, drop_count=1. 300 further windows -> drop_count=255.
- Same-cycle handshake: out_ready=1 exactly in the cycle the next window's 16th sample arrives -> no drop, overrun stays 0, outputs update to the new window.
- Mid-window disruption: 5 samples of 0xFF, then a clear pulse with a simultaneous sample_valid, then 16 x 0x10 -> mean=0x10, min=max=0x10. Repeat with a reset_n pulse instead of clear -> same result.
